id_ex_hazard_ctrl: RTL and testbench
====================================

// Module: id_ex_hazard_ctrl
// PURPOSE
//  Control-side counterpart of the ID/EX pipeline register: consumes what decode writes into it
//  and what execute reads out of it. Drives the stall/flush controls for the IF/ID and ID/EX
//  registers and the EX-stage operand forwarding selects.
//  Handles load-use hazards with multi-cycle memory latency and taken-branch flushes with a
//  configurable penalty, using a small FSM. Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  REG_AW      5   register address width
//  LOAD_LAT    1   load-use stall length in cycles (>=1)
//  BR_PENALTY  1   taken-branch flush length in cycles (>=1)
//  STALL_CNT_W 16  width of stall-cycle counter
// PORTS
//  clk              in   1            clock, rising edge
//  rst              in   1            reset, asynchronous, active-low
//  i_src1_D         in   REG_AW       decode-stage source register 1
//  i_src2_D         in   REG_AW       decode-stage source register 2
//  i_src1_E         in   REG_AW       EX-stage source register 1
//  i_src2_E         in   REG_AW       EX-stage source register 2
//  i_Write_Reg_E    in   REG_AW       EX-stage destination register
//  i_REGWrite_E     in   1            EX-stage instruction writes the register file
//  i_MEMRead_E      in   1            EX-stage instruction is a load
//  i_Branch_E       in   1            EX-stage instruction is a branch
//  i_Branch_taken_E in   1            branch resolved taken (qualified by i_Branch_E)
//  i_Write_Reg_M    in   REG_AW       MEM-stage destination register
//  i_REGWrite_M     in   1            MEM-stage register write enable
//  i_Write_Reg_W    in   REG_AW       WB-stage destination register
//  i_REGWrite_W     in   1            WB-stage register write enable
//  o_stall_F        out  1            hold PC / fetch
//  o_stall_D        out  1            hold IF/ID register
//  o_flush_D        out  1            clear IF/ID register (insert bubble)
//  o_flush_E        out  1            clear ID/EX register (insert bubble)
//  o_fwdA_E         out  2            operand A select: 00 regfile, 01 WB, 10 MEM
//  o_fwdB_E         out  2            operand B select, same encoding
//  o_state          out  2            FSM state: 0 IDLE, 1 LD_STALL, 2 BR_FLUSH
//  o_stall_cycles   out  STALL_CNT_W  cycles with o_stall_D=1, saturating
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - state IDLE; internal count 0; o_stall_cycles 0.
//   - All stall/flush outputs 0 and fwd selects 00 while rst=0, independent of the inputs.
//  Detection terms (combinational):
//   - ld_use = i_MEMRead_E & i_REGWrite_E & (i_Write_Reg_E!=0)
//     & (i_Write_Reg_E==i_src1_D | i_Write_Reg_E==i_src2_D)
//   - br = i_Branch_E & i_Branch_taken_E
//  IDLE:
//   - br=1: o_flush_D=o_flush_E=1 this cycle.
//     If BR_PENALTY>1: go to BR_FLUSH with cnt=BR_PENALTY-1.
//   - else ld_use=1: o_stall_F=o_stall_D=o_flush_E=1 this cycle.
//     If LOAD_LAT>1: go to LD_STALL with cnt=LOAD_LAT-1.
//   - br takes priority over ld_use, because the dependent instruction is being flushed.
//   - Otherwise all stall/flush outputs are 0.
//  LD_STALL:
//   - o_stall_F=o_stall_D=o_flush_E=1; br and ld_use are ignored.
//   - cnt decrements each cycle; the cycle with cnt==1 is the last, then go to IDLE.
//  BR_FLUSH:
//   - o_flush_D=o_flush_E=1, stalls 0; ld_use and br are ignored.
//   - cnt decrements each cycle; the cycle with cnt==1 is the last, then go to IDLE.
//  Resulting lengths: stall lasts exactly LOAD_LAT cycles; flush lasts exactly BR_PENALTY cycles.
//  Encoding 3 of o_state is illegal; next state is IDLE.
//  Forwarding (combinational, all states):
//   - A: 10 if i_REGWrite_M & i_Write_Reg_M!=0 & i_Write_Reg_M==i_src1_E;
//     else 01 if i_REGWrite_W & i_Write_Reg_W!=0 & i_Write_Reg_W==i_src1_E; else 00.
//   - B: same rule on i_src2_E. MEM has priority over WB. Register 0 never forwards or stalls.
//  o_stall_cycles: +1 on each clock edge where o_stall_D=1; holds at all-ones.
//  Reset mid-operation: outputs go to 0 immediately; FSM returns to IDLE; no pending stall resumes.
// TESTING
//  1. LOAD_LAT=1; E: MEMRead=1, REGWrite=1, Write_Reg=5; src1_D=5
//     -> stall_F/stall_D/flush_E=1 for 1 cycle; o_state stays 0; o_stall_cycles=1.
//  2. Same as 1 but Write_Reg_E=0, src1_D=0 -> no stall or flush; counter stays 0.
//  3. LOAD_LAT=3; load-use on src2_D=9 -> stall 3 consecutive cycles; o_state=1 in cycles 2-3;
//     back to 0 after; o_stall_cycles=3.
//  4. BR_PENALTY=2; taken branch and ld_use in the same cycle -> flush_D/flush_E=1 for 2 cycles;
//     no stall; o_state=2 in cycle 2; counter unchanged.
//  5. M and W both write r7, src1_E=7 -> fwdA=10; M REGWrite=0 -> 01;
//     both Write_Reg=0 -> 00; src2_E=7 mirrors on fwdB.
//  6. rst=0 during cycle 2 of a LOAD_LAT=3 stall -> outputs 0 at once, o_state=0, counter 0.
//     With STALL_CNT_W=4 and 20 stall cycles, counter holds at 15.

Source files
------------

// File: rtl/id_ex_hazard_ctrl.sv
// Purpose : stall/flush control for IF/ID and ID/EX plus EX operand forwarding selects.
// Latency : stall/flush/forward outputs are combinational in the current cycle; state and counter update on clk.
// Backpressure: a load-use hazard holds fetch/decode for LOAD_LAT cycles; a taken branch flushes for BR_PENALTY cycles.
module id_ex_hazard_ctrl #(
   parameter int REG_AW      = 5,
   parameter int LOAD_LAT    = 1,
   parameter int BR_PENALTY  = 1,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REG_AW-1:0]      i_src1_D,
   input  logic [REG_AW-1:0]      i_src2_D,
   input  logic [REG_AW-1:0]      i_src1_E,
   input  logic [REG_AW-1:0]      i_src2_E,
   input  logic [REG_AW-1:0]      i_Write_Reg_E,
   input  logic                   i_REGWrite_E,
   input  logic                   i_MEMRead_E,
   input  logic                   i_Branch_E,
   input  logic                   i_Branch_taken_E,
   input  logic [REG_AW-1:0]      i_Write_Reg_M,
   input  logic                   i_REGWrite_M,
   input  logic [REG_AW-1:0]      i_Write_Reg_W,
   input  logic                   i_REGWrite_W,
   output logic                   o_stall_F,
   output logic                   o_stall_D,
   output logic                   o_flush_D,
   output logic                   o_flush_E,
   output logic [1:0]             o_fwdA_E,
   output logic [1:0]             o_fwdB_E,
   output logic [1:0]             o_state,
   output logic [STALL_CNT_W-1:0] o_stall_cycles
);

   // The down-counter only has to hold the remaining cycles after the first one.
   localparam int MAX_LEN = (LOAD_LAT > BR_PENALTY) ? LOAD_LAT : BR_PENALTY;
   localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_LD_STALL = 2'd1,
      S_BR_FLUSH = 2'd2
   } state_t;

   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         cnt, cnt_nxt;
   logic                     ld_use, br;
   logic                     stall_f_c, stall_d_c, flush_d_c, flush_e_c;
   logic [1:0]               fwd_a_c, fwd_b_c;
   logic [STALL_CNT_W-1:0]   stall_cycles;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign ld_use = i_MEMRead_E & i_REGWrite_E & (i_Write_Reg_E != '0)
                 & ((i_Write_Reg_E == i_src1_D) | (i_Write_Reg_E == i_src2_D));
   assign br     = i_Branch_E & i_Branch_taken_E;

   // FSM state and remaining-cycle counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state and hazard controls; a taken branch wins since it flushes the dependent instruction.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall_f_c = 1'b0;
      stall_d_c = 1'b0;
      flush_d_c = 1'b0;
      flush_e_c = 1'b0;
      case (state)
         S_IDLE: begin
            if (br) begin
               flush_d_c = 1'b1;
               flush_e_c = 1'b1;
               if (BR_PENALTY > 1) begin
                  state_nxt = S_BR_FLUSH;
                  cnt_nxt   = CNT_W'(BR_PENALTY - 1);
               end
            end else if (ld_use) begin
               stall_f_c = 1'b1;
               stall_d_c = 1'b1;
               flush_e_c = 1'b1;
               if (LOAD_LAT > 1) begin
                  state_nxt = S_LD_STALL;
                  cnt_nxt   = CNT_W'(LOAD_LAT - 1);
               end
            end
         end
         S_LD_STALL: begin
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            flush_e_c = 1'b1;
            if (cnt <= CNT_W'(1)) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt - CNT_W'(1);
            end
         end
         S_BR_FLUSH: begin
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
            if (cnt <= CNT_W'(1)) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Operand A select: MEM result is newer than WB, so it takes priority.
   always_comb begin
      fwd_a_c = 2'b00;
      if (i_REGWrite_M && (i_Write_Reg_M != '0) && (i_Write_Reg_M == i_src1_E))
         fwd_a_c = 2'b10;
      else if (i_REGWrite_W && (i_Write_Reg_W != '0) && (i_Write_Reg_W == i_src1_E))
         fwd_a_c = 2'b01;
   end

   // Operand B select, same priority as A.
   always_comb begin
      fwd_b_c = 2'b00;
      if (i_REGWrite_M && (i_Write_Reg_M != '0) && (i_Write_Reg_M == i_src2_E))
         fwd_b_c = 2'b10;
      else if (i_REGWrite_W && (i_Write_Reg_W != '0) && (i_Write_Reg_W == i_src2_E))
         fwd_b_c = 2'b01;
   end

   // Saturating count of cycles in which decode was held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cycles <= '0;
      else if (stall_d_c && (stall_cycles != '1))
         stall_cycles <= stall_cycles + STALL_CNT_W'(1);
   end

   // Controls are forced quiet while reset is held, regardless of the inputs.
   assign o_stall_F      = rst & stall_f_c;
   assign o_stall_D      = rst & stall_d_c;
   assign o_flush_D      = rst & flush_d_c;
   assign o_flush_E      = rst & flush_e_c;
   assign o_fwdA_E       = rst ? fwd_a_c : 2'b00;
   assign o_fwdB_E       = rst ? fwd_b_c : 2'b00;
   assign o_state        = 2'(state);
   assign o_stall_cycles = stall_cycles;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Bench for id_ex_hazard_ctrl: instance A uses unit latencies, instance B uses LOAD_LAT=3, BR_PENALTY=2, 4-bit counter.
// Expected per-cycle outputs are queued when stimulus is driven and compared at the following falling edge.
// Each instance is idle (inputs zero) while the other is exercised.
module tb_id_ex_hazard_ctrl;

   typedef struct packed {
      logic [4:0] src1_D, src2_D, src1_E, src2_E, wr_E;
      logic       regw_E, memrd_E, br_E, taken_E;
      logic [4:0] wr_M;
      logic       regw_M;
      logic [4:0] wr_W;
      logic       regw_W;
   } in_t;

   typedef struct packed {
      logic        d;
      logic [3:0]  ctl;   // {stall_F, stall_D, flush_D, flush_E}
      logic [3:0]  fwd;   // {fwdA, fwdB}
      logic [1:0]  st;
      logic [15:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   in_t  ina, inb;

   logic        sfa, sda, fda, fea, sfb, sdb, fdb, feb;
   logic [1:0]  fwa_a, fwb_a, st_a, fwa_b, fwb_b, st_b;
   logic [15:0] cyc_a;
   logic [3:0]  cyc_b;

   int   checks   = 0;
   int   failures = 0;
   exp_t  exp_q[$];
   string tag_q[$];

   always #5 clk = ~clk;

   id_ex_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .BR_PENALTY(1), .STALL_CNT_W(16)) dut_a (
      .clk(clk), .rst(rst),
      .i_src1_D(ina.src1_D), .i_src2_D(ina.src2_D), .i_src1_E(ina.src1_E), .i_src2_E(ina.src2_E),
      .i_Write_Reg_E(ina.wr_E), .i_REGWrite_E(ina.regw_E), .i_MEMRead_E(ina.memrd_E),
      .i_Branch_E(ina.br_E), .i_Branch_taken_E(ina.taken_E),
      .i_Write_Reg_M(ina.wr_M), .i_REGWrite_M(ina.regw_M),
      .i_Write_Reg_W(ina.wr_W), .i_REGWrite_W(ina.regw_W),
      .o_stall_F(sfa), .o_stall_D(sda), .o_flush_D(fda), .o_flush_E(fea),
      .o_fwdA_E(fwa_a), .o_fwdB_E(fwb_a), .o_state(st_a), .o_stall_cycles(cyc_a));

   id_ex_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .BR_PENALTY(2), .STALL_CNT_W(4)) dut_b (
      .clk(clk), .rst(rst),
      .i_src1_D(inb.src1_D), .i_src2_D(inb.src2_D), .i_src1_E(inb.src1_E), .i_src2_E(inb.src2_E),
      .i_Write_Reg_E(inb.wr_E), .i_REGWrite_E(inb.regw_E), .i_MEMRead_E(inb.memrd_E),
      .i_Branch_E(inb.br_E), .i_Branch_taken_E(inb.taken_E),
      .i_Write_Reg_M(inb.wr_M), .i_REGWrite_M(inb.regw_M),
      .i_Write_Reg_W(inb.wr_W), .i_REGWrite_W(inb.regw_W),
      .o_stall_F(sfb), .o_stall_D(sdb), .o_flush_D(fdb), .o_flush_E(feb),
      .o_fwdA_E(fwa_b), .o_fwdB_E(fwb_b), .o_state(st_b), .o_stall_cycles(cyc_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      if (obs !== req) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", tag, obs, req);
      end
   endtask

   // Compare the oldest queued expectation against the selected instance.
   always @(negedge clk) begin
      exp_t  e;
      string t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         if (!e.d) begin
            chk({t, ".ctl"}, 32'({sfa, sda, fda, fea}), 32'(e.ctl));
            chk({t, ".fwd"}, 32'({fwa_a, fwb_a}),       32'(e.fwd));
            chk({t, ".st"},  32'(st_a),                 32'(e.st));
            chk({t, ".cnt"}, 32'(cyc_a),                32'(e.cnt));
         end else begin
            chk({t, ".ctl"}, 32'({sfb, sdb, fdb, feb}), 32'(e.ctl));
            chk({t, ".fwd"}, 32'({fwa_b, fwb_b}),       32'(e.fwd));
            chk({t, ".st"},  32'(st_b),                 32'(e.st));
            chk({t, ".cnt"}, 32'(cyc_b),                32'(e.cnt));
         end
      end
   end

   function automatic in_t ld(input logic [4:0] wr, input logic [4:0] s1, input logic [4:0] s2,
                              input logic memrd, input logic regw);
      in_t v = '0;
      v.wr_E = wr; v.src1_D = s1; v.src2_D = s2; v.memrd_E = memrd; v.regw_E = regw;
      return v;
   endfunction

   function automatic in_t brv(input in_t b, input logic br, input logic taken);
      b.br_E = br; b.taken_E = taken;
      return b;
   endfunction

   function automatic in_t fw(input in_t b, input logic [4:0] s1E, input logic [4:0] s2E,
                              input logic [4:0] wrM, input logic rM, input logic [4:0] wrW, input logic rW);
      b.src1_E = s1E; b.src2_E = s2E; b.wr_M = wrM; b.regw_M = rM; b.wr_W = wrW; b.regw_W = rW;
      return b;
   endfunction

   task automatic drive(input bit d, input in_t v);
      if (d) begin inb = v; ina = '0; end
      else   begin ina = v; inb = '0; end
   endtask

   task automatic push(input string tag, input bit d, input logic [3:0] ctl, input logic [3:0] fwd,
                       input logic [1:0] st, input logic [15:0] cnt);
      exp_t e;
      e.d = d; e.ctl = ctl; e.fwd = fwd; e.st = st; e.cnt = cnt;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic cyc(input string tag, input bit d, input in_t v, input logic [3:0] ctl,
                      input logic [3:0] fwd, input logic [1:0] st, input logic [15:0] cnt);
      drive(d, v);
      push(tag, d, ctl, fwd, st, cnt);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      ina = '0;
      inb = '0;
      @(posedge clk);
      #1;
      // Reset holds every control low even with hazards and forwarding hits on the inputs.
      cyc("rst_a", 0, fw(ld(5, 5, 0, 1, 1), 7, 7, 7, 1, 7, 1), 4'b0000, 4'b0000, 2'd0, 16'd0);
      cyc("rst_b", 1, brv(ld(9, 0, 9, 1, 1), 1, 1),          4'b0000, 4'b0000, 2'd0, 16'd0);
      ina = '0;
      inb = '0;
      rst = 1'b1;

      // Instance A: single-cycle load-use stall and non-stalling cases.
      cyc("t1_lduse",   0, ld(5, 5, 0, 1, 1), 4'b1101, 4'b0000, 2'd0, 16'd0);
      cyc("t1_after",   0, '0,                4'b0000, 4'b0000, 2'd0, 16'd1);
      cyc("t2_r0",      0, ld(0, 0, 0, 1, 1), 4'b0000, 4'b0000, 2'd0, 16'd1);
      cyc("t2_noregw",  0, ld(3, 0, 3, 1, 0), 4'b0000, 4'b0000, 2'd0, 16'd1);
      cyc("t2_noload",  0, ld(3, 0, 3, 0, 1), 4'b0000, 4'b0000, 2'd0, 16'd1);
      cyc("t2_src2",    0, ld(3, 0, 3, 1, 1), 4'b1101, 4'b0000, 2'd0, 16'd1);
      cyc("br_a",       0, brv('0, 1, 1),     4'b0011, 4'b0000, 2'd0, 16'd2);
      cyc("br_nt_ld",   0, brv(ld(5, 5, 0, 1, 1), 1, 0), 4'b1101, 4'b0000, 2'd0, 16'd2);
      cyc("br_ld_a",    0, brv(ld(5, 5, 0, 1, 1), 1, 1), 4'b0011, 4'b0000, 2'd0, 16'd3);

      // Instance A: forwarding priority and register-0 exclusion.
      cyc("f_mem",      0, fw('0, 7, 0, 7, 1, 7, 1), 4'b0000, 4'b1000, 2'd0, 16'd3);
      cyc("f_wb",       0, fw('0, 7, 0, 7, 0, 7, 1), 4'b0000, 4'b0100, 2'd0, 16'd3);
      cyc("f_r0",       0, fw('0, 0, 0, 0, 1, 0, 1), 4'b0000, 4'b0000, 2'd0, 16'd3);
      cyc("f_b_mem",    0, fw('0, 0, 7, 7, 1, 7, 1), 4'b0000, 4'b0010, 2'd0, 16'd3);
      cyc("f_b_wb",     0, fw('0, 0, 7, 7, 0, 7, 1), 4'b0000, 4'b0001, 2'd0, 16'd3);
      cyc("f_split",    0, fw('0, 7, 3, 3, 1, 7, 1), 4'b0000, 4'b0110, 2'd0, 16'd3);
      cyc("f_nowr",     0, fw('0, 7, 7, 7, 0, 7, 0), 4'b0000, 4'b0000, 2'd0, 16'd3);

      // Instance B: three-cycle load-use stall; branches ignored and forwarding live during it.
      cyc("t3_c1",      1, ld(9, 0, 9, 1, 1),           4'b1101, 4'b0000, 2'd0, 16'd0);
      cyc("t3_c2",      1, brv(ld(9, 0, 9, 1, 1), 1, 1), 4'b1101, 4'b0000, 2'd1, 16'd1);
      cyc("t3_c3",      1, fw('0, 7, 0, 7, 1, 0, 0),    4'b1101, 4'b1000, 2'd1, 16'd2);
      cyc("t3_done",    1, '0,                          4'b0000, 4'b0000, 2'd0, 16'd3);

      // Instance B: branch beats load-use and flushes for two cycles.
      cyc("t4_c1",      1, brv(ld(9, 0, 9, 1, 1), 1, 1), 4'b0011, 4'b0000, 2'd0, 16'd3);
      cyc("t4_c2",      1, ld(9, 0, 9, 1, 1),           4'b0011, 4'b0000, 2'd2, 16'd3);
      cyc("t4_done",    1, '0,                          4'b0000, 4'b0000, 2'd0, 16'd3);

      // Instance B: reset asserted in the second stall cycle.
      cyc("t6_c1",      1, ld(9, 0, 9, 1, 1), 4'b1101, 4'b0000, 2'd0, 16'd3);
      drive(1, fw(ld(9, 0, 9, 1, 1), 7, 7, 7, 1, 7, 1));
      #1;
      rst = 1'b0;
      push("t6_rst", 1, 4'b0000, 4'b0000, 2'd0, 16'd0);
      @(posedge clk);
      #1;
      drive(1, '0);
      rst = 1'b1;
      cyc("t6_rel",     1, '0,                         4'b0000, 4'b0000, 2'd0, 16'd0);
      cyc("t6_idle",    1, fw('0, 7, 7, 7, 1, 7, 1),   4'b0000, 4'b1010, 2'd0, 16'd0);
      cyc("t6_a",       0, '0,                         4'b0000, 4'b0000, 2'd0, 16'd0);

      // Instance B: continuous load-use pressure saturates the 4-bit counter.
      for (int k = 1; k <= 20; k++) begin
         cyc($sformatf("sat%0d", k), 1, ld(9, 0, 9, 1, 1), 4'b1101, 4'b0000,
             (((k - 1) % 3) == 0) ? 2'd0 : 2'd1, 16'((k - 1 > 15) ? 15 : k - 1));
      end
      cyc("sat_tail",   1, '0, 4'b1101, 4'b0000, 2'd1, 16'd15);
      cyc("sat_hold",   1, '0, 4'b0000, 4'b0000, 2'd0, 16'd15);

      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
